// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Accepts one ALU operation per start/done handshake, drives the ALU operand
//   and opcode inputs from registers, and captures the ALU result into LO/HI.
//   Single-cycle ops finish in a fixed EXEC cycle. DIV pulses the divider reset
//   and then waits a counted number of cycles. Divide-by-zero and unsupported
//   opcodes finish immediately with out_err set.
//
// Ports
//   clk, in_reset_n                   clock, asynchronous active-low reset
//   in_start, in_opcode, in_a, in_b   request and its operands (sampled in IDLE)
//   in_alu_result                     ALU result (HI = [63:32], LO = [31:0])
//   out_alu_a/b/opcode                registered ALU inputs, held until the next accept
//   out_div_reset                     one-cycle divider reset pulse
//   out_busy, out_done                busy outside IDLE, one-cycle completion pulse
//   out_err                           error flag, cleared on the next accept
//   out_lo, out_hi                    result registers
module alu_op_sequencer #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        in_reset_n,
  input  logic        in_start,
  input  logic [3:0]  in_opcode,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [63:0] in_alu_result,
  output logic [31:0] out_alu_a,
  output logic [31:0] out_alu_b,
  output logic [3:0]  out_alu_opcode,
  output logic        out_div_reset,
  output logic        out_busy,
  output logic        out_done,
  output logic        out_err,
  output logic [31:0] out_lo,
  output logic [31:0] out_hi
);

  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_DIV   = 4'b1001;
  localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    DIV_RST,
    DIV_WAIT,
    DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] alu_a_nxt, alu_b_nxt, lo_nxt, hi_nxt;
  logic [3:0]  alu_opcode_nxt;
  logic        err_nxt;

  // Control outputs are pure state decodes, so reset forces them to 0 along with the state.
  assign out_busy      = (state != IDLE);
  assign out_done      = (state == DONE);
  assign out_div_reset = (state == DIV_RST);

  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      out_alu_a      <= 32'd0;
      out_alu_b      <= 32'd0;
      out_alu_opcode <= 4'd0;
      out_err        <= 1'b0;
      out_lo         <= 32'd0;
      out_hi         <= 32'd0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      out_alu_a      <= alu_a_nxt;
      out_alu_b      <= alu_b_nxt;
      out_alu_opcode <= alu_opcode_nxt;
      out_err        <= err_nxt;
      out_lo         <= lo_nxt;
      out_hi         <= hi_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    alu_a_nxt      = out_alu_a;
    alu_b_nxt      = out_alu_b;
    alu_opcode_nxt = out_alu_opcode;
    err_nxt        = out_err;
    lo_nxt         = out_lo;
    hi_nxt         = out_hi;

    case (state)
      IDLE: begin
        if (in_start) begin
          alu_a_nxt      = in_a;
          alu_b_nxt      = in_b;
          alu_opcode_nxt = in_opcode;
          err_nxt        = 1'b0;
          if (in_opcode == OP_DIV) begin
            if (in_b == 32'd0) begin
              // Divide-by-zero never reaches the divider; report saturated quotient, dividend as remainder.
              err_nxt   = 1'b1;
              lo_nxt    = 32'hFFFF_FFFF;
              hi_nxt    = in_a;
              state_nxt = DONE;
            end else begin
              state_nxt = DIV_RST;
            end
          end else if (in_opcode[3:2] == 2'b11) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = EXEC;
          end
        end
      end

      EXEC: begin
        lo_nxt = in_alu_result[31:0];
        if (out_alu_opcode == OP_MUL) begin
          hi_nxt = in_alu_result[63:32];
        end
        state_nxt = DONE;
      end

      DIV_RST: begin
        cnt_nxt   = CNT_LOAD;
        state_nxt = DIV_WAIT;
      end

      DIV_WAIT: begin
        // The divider output is sampled in the cycle the counter reaches 0,
        // which is DIV_CYCLES cycles after the reset pulse ended.
        if (cnt == 8'd0) begin
          lo_nxt    = in_alu_result[31:0];
          hi_nxt    = in_alu_result[63:32];
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
